// File: rtl/bram_data_arbiter.sv
// bram_data_arbiter: round-robin two-port sequencer framing each request as one BRAM access
// with a forced idle cycle after completion and a per-access timeout.
module bram_data_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_byte_sel,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_byte_sel,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic        p1_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_sel,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state, w_next;
    logic [1:0] r_req;
    logic       r_last;
    logic       r_owner;
    logic [7:0] r_cnt;
    logic       w_sel, w_ready, w_tmo;

    always_comb begin
        w_sel   = (&r_req) ? ~r_last : r_req[1];
        w_ready = (r_state == ACCESS) && mem_ready;
        w_tmo   = (r_state == ACCESS) && !mem_ready && (r_cnt == TMO_LAST);
        w_next  = r_state;
        case (r_state)
            IDLE:    w_next = (|r_req) ? ACCESS : IDLE;
            ACCESS:  w_next = (w_ready || w_tmo) ? RELEASE : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    // Requests are registered, so the grant lands one edge after sampling.
    // The mem_* registers double as the latched access fields while in ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req        <= 2'b00;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= 8'd0;
            mem_ce       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_byte_sel <= 4'd0;
            p0_rdata     <= 32'd0;
            p1_rdata     <= 32'd0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            p0_err       <= 1'b0;
            p1_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= {p1_req, p0_req};
            r_cnt   <= (r_state == ACCESS) ? r_cnt + 8'd1 : 8'd0;
            if (r_state == IDLE && |r_req) begin
                r_owner      <= w_sel;
                r_last       <= w_sel;
                mem_ce       <= 1'b1;
                mem_we       <= w_sel ? p1_we : p0_we;
                mem_addr     <= w_sel ? p1_addr : p0_addr;
                mem_wdata    <= w_sel ? p1_wdata : p0_wdata;
                mem_byte_sel <= w_sel ? p1_byte_sel : p0_byte_sel;
            end else if (w_next != ACCESS) begin
                mem_ce       <= 1'b0;
                mem_we       <= 1'b0;
                mem_addr     <= 32'd0;
                mem_wdata    <= 32'd0;
                mem_byte_sel <= 4'd0;
            end
            p0_done <= w_ready && !r_owner;
            p1_done <= w_ready && r_owner;
            p0_err  <= w_tmo && !r_owner;
            p1_err  <= w_tmo && r_owner;
            if (w_ready && !mem_we && !r_owner)
                p0_rdata <= mem_rdata;
            if (w_ready && !mem_we && r_owner)
                p1_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_bram_data_arbiter.sv
// tb_bram_data_arbiter: directed checks of framing, round-robin, timeout, reset and spurious ready
// against a small BRAM model that answers two cycles after mem_ce rises.
module tb_bram_data_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_byte_sel, p1_byte_sel;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p1_done, p0_err, p1_err;
    logic        mem_ce, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_sel;

    logic        bram_en, spur, r_rdy;
    logic [1:0]  c;
    logic [3:0]  idx;
    logic [31:0] mem [16] = '{4: 32'hDEADBEEF, default: 32'h0};
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    bram_data_arbiter #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_byte_sel(p0_byte_sel), .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_byte_sel(p1_byte_sel), .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_sel(mem_byte_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    assign mem_ready = r_rdy | spur;
    assign idx       = 4'(mem_addr >> 2);

    // BRAM model: ready pulses on the third edge of an enabled access.
    always @(posedge clk) begin
        if (!mem_ce) begin
            r_rdy <= 1'b0;
            c     <= 2'd0;
        end else if (r_rdy) begin
            r_rdy <= 1'b0;
        end else if (c == 2'd1) begin
            if (bram_en) begin
                r_rdy <= 1'b1;
                c     <= 2'd0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_byte_sel[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    mem_rdata <= mem[idx];
                end
            end
        end else begin
            c <= c + 2'd1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; spur = 1'b0; bram_en = 1'b1; mem_rdata = 32'h0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_byte_sel = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_byte_sel = 0;
        cyc(2);
        chk("rst_ce", {31'd0, mem_ce}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_done", {30'd0, p1_done, p0_done}, 0);
        rst = 1'b0;
        cyc(1);

        // single read, port 0
        p0_addr = 32'h10; p0_we = 1'b0; p0_req = 1'b1;
        cyc(1);
        chk("t1_ce_e0", {31'd0, mem_ce}, 0);
        cyc(1);
        chk("t1_ce_e1", {31'd0, mem_ce}, 1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_we", {31'd0, mem_we}, 0);
        cyc(2);
        chk("t1_ce_e3", {31'd0, mem_ce}, 1);
        chk("t1_done_e3", {31'd0, p0_done}, 0);
        cyc(1);
        chk("t1_done_e4", {31'd0, p0_done}, 1);
        chk("t1_ce_e4", {31'd0, mem_ce}, 0);
        chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
        p0_req = 1'b0;
        cyc(1);
        chk("t1_done_e5", {31'd0, p0_done}, 0);

        // write then read, port 1
        p1_addr = 32'h20; p1_we = 1'b1; p1_wdata = 32'h11223344; p1_byte_sel = 4'b0011; p1_req = 1'b1;
        cyc(2);
        chk("t2_we", {31'd0, mem_we}, 1);
        chk("t2_bsel", {28'd0, mem_byte_sel}, 32'h3);
        chk("t2_wdata", mem_wdata, 32'h11223344);
        cyc(3);
        chk("t2_wr_done", {31'd0, p1_done}, 1);
        chk("t2_wr_rdata", p1_rdata, 0);
        p1_req = 1'b0;
        cyc(1);
        p1_we = 1'b0; p1_req = 1'b1;
        cyc(5);
        chk("t2_rd_done", {31'd0, p1_done}, 1);
        chk("t2_rd_rdata", p1_rdata, 32'h00003344);
        p1_req = 1'b0;
        cyc(1);

        // both ports continuous: 0,1,0,1 five cycles apart
        p0_req = 1'b1; p1_req = 1'b1;
        cyc(5);
        chk("t3_g0_p0", {31'd0, p0_done}, 1);
        chk("t3_g0_p1", {31'd0, p1_done}, 0);
        chk("t3_ce_rel", {31'd0, mem_ce}, 0);
        cyc(1);
        chk("t3_ce_idle", {31'd0, mem_ce}, 0);
        cyc(4);
        chk("t3_g1_p1", {31'd0, p1_done}, 1);
        chk("t3_g1_p0", {31'd0, p0_done}, 0);
        cyc(5);
        chk("t3_g2_p0", {31'd0, p0_done}, 1);
        cyc(5);
        chk("t3_g3_p1", {31'd0, p1_done}, 1);
        p0_req = 1'b0; p1_req = 1'b0;
        cyc(1);

        // timeout on port 0, then port 1 served
        bram_en = 1'b0; p0_req = 1'b1; p1_req = 1'b1;
        cyc(16);
        chk("t4_err_e15", {31'd0, p0_err}, 0);
        cyc(1);
        chk("t4_err_e16", {31'd0, p0_err}, 1);
        chk("t4_done_e16", {31'd0, p0_done}, 0);
        chk("t4_rdata", p0_rdata, 32'hDEADBEEF);
        p0_req = 1'b0; bram_en = 1'b1;
        cyc(5);
        chk("t4_p1_done", {31'd0, p1_done}, 1);
        chk("t4_p1_rdata", p1_rdata, 32'h00003344);
        chk("t4_p0_err", {31'd0, p0_err}, 0);
        p1_req = 1'b0;
        cyc(1);

        // reset mid-access
        p0_req = 1'b1;
        cyc(3);
        rst = 1'b1;
        #1;
        chk("t5_ce", {31'd0, mem_ce}, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_p0_rdata", p0_rdata, 0);
        chk("t5_p1_rdata", p1_rdata, 0);
        cyc(2);
        chk("t5_no_done", {31'd0, p0_done}, 0);
        rst = 1'b0;
        cyc(5);
        chk("t5_fresh_done", {31'd0, p0_done}, 1);
        chk("t5_fresh_rdata", p0_rdata, 32'hDEADBEEF);
        p0_req = 1'b0;
        cyc(1);

        // spurious mem_ready in IDLE
        spur = 1'b1;
        cyc(1);
        spur = 1'b0;
        chk("t6_done", {30'd0, p1_done, p0_done}, 0);
        chk("t6_err", {30'd0, p1_err, p0_err}, 0);
        cyc(1);
        chk("t6_done2", {30'd0, p1_done, p0_done}, 0);
        chk("t6_rdata", p0_rdata, 32'hDEADBEEF);
        p0_req = 1'b1; p1_req = 1'b1;
        cyc(5);
        chk("t6_tie_p1", {31'd0, p1_done}, 1);
        chk("t6_tie_p0", {31'd0, p0_done}, 0);
        p1_req = 1'b0;
        cyc(5);
        chk("t6_then_p0", {31'd0, p0_done}, 1);
        p0_req = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bram_data_arbiter.md
# bram_data_arbiter

Two-port arbiter and sequencer in front of the data BRAM wrapper. It shares the single data BRAM between the CPU load/store unit (port 0) and the program/debug loader (port 1). It turns each level-held request into one properly framed BRAM transaction: `mem_ce` rises, the arbiter waits for the `mem_ready` pulse, then forces one idle cycle with `mem_ce` low so the next access produces a fresh rising edge. A per-access timeout prevents a lost `mem_ready` from hanging either requester.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 15: maximum cycles in ACCESS without `mem_ready` before the access is aborted. Legal range 4..255.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `p0_req`, `p1_req` in 1 each: access request, level; held until the matching done or err pulse.
- `p0_we`, `p1_we` in 1 each: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in 32 each: byte address.
- `p0_wdata`, `p1_wdata` in 32 each: write data.
- `p0_byte_sel`, `p1_byte_sel` in 4 each: byte enables for writes.
- `p0_rdata`, `p1_rdata` out 32 each: registered read data, held until that port's next read completes.
- `p0_done`, `p1_done` out 1 each: one-cycle completion pulse.
- `p0_err`, `p1_err` out 1 each: one-cycle timeout pulse.
- `mem_ce` out 1: BRAM enable.
- `mem_we` out 1: BRAM write enable.
- `mem_addr` out 32: BRAM address.
- `mem_wdata` out 32: BRAM write data.
- `mem_byte_sel` out 4: BRAM byte enables.
- `mem_rdata` in 32: BRAM read data.
- `mem_ready` in 1: BRAM completion pulse.

## Operation
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE, when any request is high:
  - Choose the owner.
  - Latch the owner's `we`, `addr`, `wdata` and `byte_sel` into internal registers.
  - Go to ACCESS.
- Arbitration is round-robin over a 1-bit `last_grant` register:
  - Only one request high: grant that port.
  - Both requests high: grant the port not equal to `last_grant`.
  - `last_grant` updates on every grant.
- ACCESS:
  - `mem_ce`=1 and the mem_* outputs carry the latched fields.
  - The timeout counter increments each cycle.
- ACCESS with `mem_ready`=1:
  - Owner's done pulses next cycle.
  - On a read, capture `mem_rdata` into the owner's rdata.
  - On a write, rdata is unchanged.
  - Go to RELEASE.
- ACCESS with the counter reaching `TIMEOUT_CYCLES`-1 and no `mem_ready`:
  - Owner's err pulses; done does not pulse; rdata is unchanged.
  - Go to RELEASE.
- RELEASE: all mem_* outputs are 0 for exactly one cycle, then IDLE.
- Outside ACCESS, every mem_* output is 0 (`mem_we`=0, `mem_byte_sel`=0).
- `mem_ready` seen in IDLE or RELEASE is ignored: no done pulse, no state change.
- The owner dropping its request mid-ACCESS does not abort the access; done or err still pulses.
- A request arriving during ACCESS or RELEASE waits; it is evaluated in the next IDLE.
- `mem_ready` and timeout in the same cycle: `mem_ready` wins (done, no err).

## Timing
- All outputs are registered.
- Reset values:
  - Outputs: all 0, including both rdata ports and all mem_* outputs.
  - FSM: IDLE.
  - `last_grant`: 1, so port 0 wins the first tie.
  - Timeout counter: 0.
- Reset asserted mid-access clears everything immediately (asynchronous). No done or err pulse is produced for the interrupted access.
- Request sampled high at edge E0 (IDLE):
  - `mem_ce` high after E1.
  - BRAM `mem_ready` high during E3–E4.
  - done and rdata valid after E4.
  - `mem_ce` low during the RELEASE cycle E4–E5.
  - Back in IDLE after E5.
- Throughput: one access per 5 cycles with continuous requests.
- Done-to-next-grant: a requester holding `req` through its done cycle is re-sampled at E5.
- Timeout: err pulses `TIMEOUT_CYCLES`+1 cycles after the accept edge.
- Write and read latency are identical.

## Test plan
- Single read, port 0, `addr`=0x10, BRAM word 0xDEADBEEF:
  - `mem_ce` high for 3 cycles, then low for 1 cycle.
  - `p0_done` pulses 4 cycles after the accept edge.
  - `p0_rdata`=0xDEADBEEF.
- Write then read, port 1, `addr`=0x20, `wdata`=0x11223344, `byte_sel`=0011; then read the same address with prior contents 0:
  - Read returns 0x00003344.
  - `p1_rdata` is unchanged by the write.
- Both ports request continuously:
  - Grants alternate 0,1,0,1.
  - Each done is 5 cycles apart.
  - `mem_ce` falls to 0 between every pair of accesses.
- `mem_ready` tied 0, `TIMEOUT_CYCLES`=15:
  - `p0_err` pulses 16 cycles after accept; no done.
  - FSM returns to IDLE and serves port 1 next.
- Reset asserted at E2 of a port-0 read:
  - All outputs 0 immediately; no done pulse.
  - After release, a fresh port-0 read completes normally.
- Spurious `mem_ready` pulse in IDLE: no done or err pulse; `last_grant` and rdata unchanged.
